// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART byte transmitter
//               between NUM_REQ byte sources. A winner's byte is latched and
//               handed to the transmitter with a one-cycle tx_start. The block
//               then waits for tx_busy to rise and fall, and pulses ack to the
//               winner. If tx_busy never rises within BUSY_TIMEOUT cycles, the
//               grant is abandoned with a one-cycle err_timeout pulse.
// Ports       : clk, rst (async, active-high)
//               req[NUM_REQ], req_data[8*NUM_REQ]  - requester side
//               ack[NUM_REQ]                       - per-requester done pulse
//               tx_start, tx_data[8], tx_busy      - transmitter side
//               grant_id, active, err_timeout      - status
// Option      : UART_TX_ARB_TAG_EN - each grant first sends a tag byte
//               {4'hA, grant_id}, then the data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_CW  = $clog2(BUSY_TIMEOUT);
    // Abort on the edge where the counter would reach BUSY_TIMEOUT-1.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(BUSY_TIMEOUT - 2);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_START     = 3'd1;
    localparam logic [2:0] c_S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_S_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_S_DONE      = 3'd4;

    logic [2:0]         r_state,    w_stateNext;
    logic [c_IDW-1:0]   r_rrPtr,    w_rrPtrNext;
    logic [c_IDW-1:0]   r_grant,    w_grantNext;
    logic [7:0]         r_txData,   w_txDataNext;
    logic [c_CW-1:0]    r_cnt,      w_cntNext;
    logic [NUM_REQ-1:0] r_ack,      w_ackNext;
    logic               r_txStart,  w_txStartNext;
    logic               r_active,   w_activeNext;
    logic               r_errTo,    w_errToNext;
`ifdef UART_TX_ARB_TAG_EN
    logic               r_phase,    w_phaseNext;     // 0: tag byte, 1: data byte
    logic [7:0]         r_dataByte, w_dataByteNext;
`endif

    logic [7:0]         w_reqBytes [NUM_REQ];
    logic               w_found;
    logic [c_IDW-1:0]   w_winner;
    logic [c_IDW-1:0]   w_cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_reqBytes
        assign w_reqBytes[gi] = req_data[8*gi +: 8];
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = c_IDW'((int'(r_rrPtr) + i) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_rrPtrNext    = r_rrPtr;
        w_grantNext    = r_grant;
        w_txDataNext   = r_txData;
        w_cntNext      = r_cnt;
        w_ackNext      = '0;
        w_errToNext    = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
        w_phaseNext    = r_phase;
        w_dataByteNext = r_dataByte;
`endif
        case (r_state)
            c_S_IDLE: begin
                // A busy transmitter in IDLE belongs to someone else; hold off.
                if (w_found && !tx_busy) begin
                    w_stateNext = c_S_START;
                    w_grantNext = w_winner;
`ifdef UART_TX_ARB_TAG_EN
                    w_txDataNext   = {4'hA, 4'(w_winner)};
                    w_dataByteNext = w_reqBytes[w_winner];
                    w_phaseNext    = 1'b0;
`else
                    w_txDataNext = w_reqBytes[w_winner];
`endif
                end
            end
            c_S_START: begin
                w_cntNext   = '0;
                w_stateNext = c_S_WAIT_BUSY;
            end
            c_S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_stateNext = c_S_WAIT_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    // rr_ptr untouched: the aborted requester keeps its priority.
                    w_stateNext = c_S_IDLE;
                    w_errToNext = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                    w_phaseNext = 1'b0;
`endif
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            c_S_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_ARB_TAG_EN
                    if (!r_phase) begin
                        w_phaseNext  = 1'b1;
                        w_txDataNext = r_dataByte;
                        w_stateNext  = c_S_START;
                    end else begin
                        w_stateNext = c_S_DONE;
                        w_ackNext[r_grant] = 1'b1;
                    end
`else
                    w_stateNext = c_S_DONE;
                    w_ackNext[r_grant] = 1'b1;
`endif
                end
            end
            c_S_DONE: begin
                w_rrPtrNext = r_grant;
                w_stateNext = c_S_IDLE;
`ifdef UART_TX_ARB_TAG_EN
                w_phaseNext = 1'b0;
`endif
            end
            default: begin
                w_stateNext = c_S_IDLE;
            end
        endcase
        // Outputs are registered versions of what the next state implies.
        w_txStartNext = (w_stateNext == c_S_START);
        w_activeNext  = (w_stateNext != c_S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_rrPtr    <= c_IDW'(NUM_REQ - 1);
            r_grant    <= '0;
            r_txData   <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_txStart  <= 1'b0;
            r_active   <= 1'b0;
            r_errTo    <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
            r_phase    <= 1'b0;
            r_dataByte <= '0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_rrPtr    <= w_rrPtrNext;
            r_grant    <= w_grantNext;
            r_txData   <= w_txDataNext;
            r_cnt      <= w_cntNext;
            r_ack      <= w_ackNext;
            r_txStart  <= w_txStartNext;
            r_active   <= w_activeNext;
            r_errTo    <= w_errToNext;
`ifdef UART_TX_ARB_TAG_EN
            r_phase    <= w_phaseNext;
            r_dataByte <= w_dataByteNext;
`endif
        end
    end

    assign ack         = r_ack;
    assign tx_start    = r_txStart;
    assign tx_data     = r_txData;
    assign grant_id    = r_grant;
    assign active      = r_active;
    assign err_timeout = r_errTo;

endmodule
`default_nettype wire
